// File: rtl/mem_port_arbiter.sv
// Three-way line arbiter in front of the SDRAM controller port: p1 program cache, p2 data cache, p3 video.
// Default build uses fixed priority p3 > p2 > p1; define ARB_ROUND_ROBIN_EN for round robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic              p1_req,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p2_address,
  input  logic [DATA_W-1:0] p2_to_mem,
  input  logic              p2_req,
  input  logic              p2_wren,
  output logic              p2_ready,
  input  logic [ADDR_W-1:0] p3_address,
  input  logic [DATA_W-1:0] p3_to_mem,
  input  logic              p3_req,
  input  logic              p3_wren,
  output logic              p3_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_to_mem,
  output logic              mem_req,
  output logic              mem_wren,
  input  logic              mem_ready,
  input  logic [1:0]        mem_offset,
  output logic [2:0]        grant
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] req_vec;
  logic [2:0] winner;
  logic       busy;
  logic       line_done;

  assign req_vec   = {p3_req, p2_req, p1_req};
  assign busy      = (state_q == S_BUSY);
  assign line_done = busy && mem_ready && (mem_offset == 2'd3);

  function automatic logic [2:0] pick_fixed(input logic [2:0] req);
    logic [2:0] win;
    win = 3'b000;
    if (req[2])      win = 3'b100;
    else if (req[1]) win = 3'b010;
    else if (req[0]) win = 3'b001;
    return win;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  // Search begins at the requester after the previous winner, wrapping p3 -> p1.
  function automatic logic [2:0] pick_rr(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] win;
    win = 3'b000;
    case (last)
      2'd1: begin
        if (req[1])      win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd2: begin
        if (req[2])      win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0])      win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
    return win;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd3;
    if (oh[0])      idx = 2'd1;
    else if (oh[1]) idx = 2'd2;
    return idx;
  endfunction

  assign winner = pick_rr(req_vec, last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && (|req_vec)) last_d = onehot_to_idx(winner);
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 2'd3;
    else     last_q <= last_d;
  end
`else
  assign winner = pick_fixed(req_vec);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (|req_vec) begin
          grant_d = winner;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Owner keeps the port until offset 3 even if it drops req mid-line.
        if (line_done) begin
          grant_d = 3'b000;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 3'b000;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    mem_address = '0;
    mem_to_mem  = '0;
    mem_wren    = 1'b0;
    case (grant_q)
      3'b001: begin
        mem_address = p1_address;
      end
      3'b010: begin
        mem_address = p2_address;
        mem_to_mem  = p2_to_mem;
        mem_wren    = p2_wren;
      end
      3'b100: begin
        mem_address = p3_address;
        mem_to_mem  = p3_to_mem;
        mem_wren    = p3_wren;
      end
      default: ;
    endcase
  end

  assign mem_req  = busy;
  assign grant    = grant_q;
  assign p1_ready = busy & mem_ready & grant_q[0];
  assign p2_ready = busy & mem_ready & grant_q[1];
  assign p3_ready = busy & mem_ready & grant_q[2];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow the active arbitration mode.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [23:0] p1_address, p2_address, p3_address;
  logic [15:0] p2_to_mem, p3_to_mem;
  logic        p1_req, p2_req, p3_req;
  logic        p2_wren, p3_wren;
  logic        p1_ready, p2_ready, p3_ready;
  logic [23:0] mem_address;
  logic [15:0] mem_to_mem;
  logic        mem_req, mem_wren, mem_ready;
  logic [1:0]  mem_offset;
  logic [2:0]  grant;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(24), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .p1_address(p1_address), .p1_req(p1_req), .p1_ready(p1_ready),
    .p2_address(p2_address), .p2_to_mem(p2_to_mem), .p2_req(p2_req),
    .p2_wren(p2_wren), .p2_ready(p2_ready),
    .p3_address(p3_address), .p3_to_mem(p3_to_mem), .p3_req(p3_req),
    .p3_wren(p3_wren), .p3_ready(p3_ready),
    .mem_address(mem_address), .mem_to_mem(mem_to_mem), .mem_req(mem_req),
    .mem_wren(mem_wren), .mem_ready(mem_ready), .mem_offset(mem_offset),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One word beat: readies are sampled combinationally before the edge.
  task automatic word(input logic [1:0] off, input logic [2:0] exp_grant);
    mem_ready  = 1'b1;
    mem_offset = off;
    #1;
    chk("word_grant", 32'(grant), 32'(exp_grant));
    chk("word_ready", 32'({p3_ready, p2_ready, p1_ready}), 32'(exp_grant));
    chk("word_req", 32'(mem_req), 32'd1);
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic line(input logic [2:0] exp_grant);
    for (int k = 0; k < 4; k++) word(2'(k), exp_grant);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
  endtask

  logic [2:0] exp_seq [4];

  initial begin
    rst = 1'b1;
    p1_address = '0; p2_address = '0; p3_address = '0;
    p2_to_mem = '0; p3_to_mem = '0;
    p1_req = 0; p2_req = 0; p3_req = 0; p2_wren = 0; p3_wren = 0;
    mem_ready = 0; mem_offset = 2'd0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ready", 32'({p3_ready, p2_ready, p1_ready}), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data", 32'(mem_to_mem), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    rst = 1'b0;
    tick();

    // Single p2 write line, with a gap beat in the middle
    p2_address = 24'h000120; p2_to_mem = 16'hBEEF; p2_wren = 1; p2_req = 1;
    tick();
    chk("p2_grant", 32'(grant), 32'h2);
    chk("p2_req", 32'(mem_req), 32'd1);
    chk("p2_wren", 32'(mem_wren), 32'd1);
    chk("p2_addr", 32'(mem_address), 32'h000120);
    chk("p2_data", 32'(mem_to_mem), 32'hBEEF);
    word(2'd0, 3'b010);
    tick();
    chk("p2_gap_req", 32'(mem_req), 32'd1);
    chk("p2_gap_ready", 32'({p3_ready, p2_ready, p1_ready}), 32'd0);
    word(2'd1, 3'b010);
    word(2'd2, 3'b010);
    word(2'd3, 3'b010);
    chk_quiet("p2_release");
    chk("p2_release_addr", 32'(mem_address), 32'd0);
    p2_req = 0; p2_wren = 0;
    tick();
    chk_quiet("p2_idle");
    tick();
    chk_quiet("p2_idle2");

    // All three requesting continuously
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
`else
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b100; exp_seq[2] = 3'b100; exp_seq[3] = 3'b100;
`endif
    p1_address = 24'h111111; p2_address = 24'h222222; p3_address = 24'h333333;
    p3_to_mem = 16'h3C3C; p3_wren = 1;
    p1_req = 1; p2_req = 1; p3_req = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("all_grant", 32'(grant), 32'(exp_seq[i]));
      chk("all_req", 32'(mem_req), 32'd1);
      line(exp_seq[i]);
      chk_quiet("all_release");
      if (i == 3) begin
        p1_req = 0; p2_req = 0; p3_req = 0;
      end
      tick();
      chk_quiet("all_idle");
      tick();
    end
    chk_quiet("all_end");
    p3_wren = 0;

    // p1 read; p3 arrives at offset 1 and must wait for RELEASE/IDLE
    do_reset();
    p1_address = 24'h0ABCDE; p3_address = 24'h0F0F00; p1_req = 1;
    tick();
    chk("p1_grant", 32'(grant), 32'h1);
    chk("p1_wren", 32'(mem_wren), 32'd0);
    chk("p1_data", 32'(mem_to_mem), 32'd0);
    chk("p1_addr", 32'(mem_address), 32'h0ABCDE);
    word(2'd0, 3'b001);
    p3_req = 1;
    word(2'd1, 3'b001);
    word(2'd2, 3'b001);
    word(2'd3, 3'b001);
    chk_quiet("p1_release");
    p1_req = 0;
    tick();
    chk_quiet("p1_idle");
    tick();
    chk("p3_after_p1_grant", 32'(grant), 32'h4);
    chk("p3_after_p1_addr", 32'(mem_address), 32'h0F0F00);
    line(3'b100);
    p3_req = 0;
    tick();
    tick();

    // Reset at offset 2 of a p3 line, then p1 waiting
    do_reset();
    p3_req = 1;
    tick();
    chk("rstmid_grant", 32'(grant), 32'h4);
    word(2'd0, 3'b100);
    word(2'd1, 3'b100);
    mem_ready = 1; mem_offset = 2'd2; rst = 1;
    p3_req = 0; p1_req = 1;
    tick();
    mem_ready = 0;
    #1;
    chk_quiet("rstmid_after");
    chk("rstmid_addr", 32'(mem_address), 32'd0);
    chk("rstmid_wren", 32'(mem_wren), 32'd0);
    rst = 0;
    tick();
    chk("rstmid_p1_grant", 32'(grant), 32'h1);
    line(3'b001);
    p1_req = 0;
    tick();
    tick();

    // Stray ready with offset 3 while IDLE
    chk_quiet("stray_pre");
    mem_ready = 1; mem_offset = 2'd3;
    #1;
    chk("stray_ready", 32'({p3_ready, p2_ready, p1_ready}), 32'd0);
    chk("stray_req", 32'(mem_req), 32'd0);
    tick();
    chk_quiet("stray_post");
    mem_ready = 0;
    p2_req = 1;
    tick();
    chk("stray_then_p2", 32'(grant), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
